// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered display data.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses digits above the highest
// nonzero nibble of the displayed value).
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      r_div_cnt;
  logic [IDX_W-1:0]      r_digit_idx;
  logic [VAL_W-1:0]      r_pend_value;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic [NUM_DIGITS-1:0] r_pend_blank;
  logic                  r_pend_vld;
  logic [VAL_W-1:0]      r_act_value;
  logic [NUM_DIGITS-1:0] r_act_dp;
  logic [NUM_DIGITS-1:0] r_act_blank;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_tick;

  logic                  w_div_wrap;
  logic                  w_last_digit;
  logic                  w_boundary;
  logic [3:0]            w_nibble;
  logic                  w_dp_bit;
  logic                  w_blank_bit;
  logic                  w_suppress;
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic [NUM_DIGITS-1:0] w_an;
  logic [7:0]            w_seg;

  // Hex nibble to active-low g..a segment pattern
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_div_wrap   = (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last_digit = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_boundary   = w_div_wrap && w_last_digit;

`ifdef LEADING_ZERO_BLANK_EN
  // Mark digits whose nibble and all nibbles above it are zero; digit 0 always shows
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    w_lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_act_value[4*i +: 4] != 4'h0) zero_run = 1'b0;
      w_lz_mask[i] = zero_run && (i != 0);
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  // Select the active digit's data and build its anode pattern
  always_comb begin
    w_nibble    = 4'h0;
    w_dp_bit    = 1'b0;
    w_blank_bit = 1'b0;
    w_suppress  = 1'b0;
    w_an        = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) begin
        w_nibble    = r_act_value[4*i +: 4];
        w_dp_bit    = r_act_dp[i];
        w_blank_bit = r_act_blank[i];
        w_suppress  = w_lz_mask[i];
        w_an[i]     = 1'b0;
      end
    end
  end

  // Segment pattern: explicit blank wins, suppression keeps only the dp
  always_comb begin
    w_seg = 8'hFF;
    if (w_blank_bit) begin
      w_seg = 8'hFF;
    end else if (w_suppress) begin
      w_seg = {~w_dp_bit, 7'h7F};
    end else begin
      w_seg = {~w_dp_bit, hex7(w_nibble)};
    end
  end

  // Scan timing: per-digit dwell counter and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + CNT_W'(1);
      if (w_div_wrap) begin
        r_digit_idx <= w_last_digit ? '0 : r_digit_idx + IDX_W'(1);
      end
    end
  end

  // Double buffer: loads land in pending, promoted to active only at a frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_vld   <= 1'b0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
    end else if (w_boundary) begin
      r_pend_vld <= 1'b0;
      if (load) begin
        r_act_value <= value;
        r_act_dp    <= dp;
        r_act_blank <= blank;
      end else if (r_pend_vld) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
        r_act_blank <= r_pend_blank;
      end
    end else if (load) begin
      r_pend_value <= value;
      r_pend_dp    <= dp;
      r_pend_blank <= blank;
      r_pend_vld   <= 1'b1;
    end
  end

  // Registered outputs: seg and an change together, frame_tick follows the boundary edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg        <= 8'hFF;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg;
      r_an         <= w_an;
      r_frame_tick <= w_boundary;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (REFRESH_DIV=4, NUM_DIGITS=4).
module tb_seven_seg_scanner;

  localparam int unsigned R  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned FR = R * N;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(R), .NUM_DIGITS(N)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp), .blank(blank),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle count since reset plus the displayed/pending data sets
  int          m_c;
  logic [15:0] m_av, m_pv;
  logic [3:0]  m_adp, m_pdp, m_ab, m_pb;
  logic        m_pvld;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_ft;
  logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [7:0] ref_pat(int d);
    logic [15:0] sh;
    sh = m_av >> (4 * d);
    if (m_ab[d]) return 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0 && sh == 16'h0) return m_adp[d] ? 8'h7F : 8'hFF;
`endif
    return {~m_adp[d], tbl[sh[3:0]]};
  endfunction

  // Predict outputs for the coming edge, advance the model, then clock and settle
  task automatic step();
    int d;
    bit bnd;
    if (reset) begin
      m_c = 0; m_av = '0; m_pv = '0; m_adp = '0; m_pdp = '0; m_ab = '0; m_pb = '0;
      m_pvld = 1'b0;
      exp_seg = 8'hFF; exp_an = 4'hF; exp_ft = 1'b0;
    end else begin
      d       = (m_c / R) % N;
      exp_seg = ref_pat(d);
      exp_an  = 4'hF & ~(4'(1) << d);
      bnd     = ((m_c % FR) == FR - 1);
      exp_ft  = bnd;
      if (load) begin
        if (bnd) begin
          m_av = value; m_adp = dp; m_ab = blank; m_pvld = 1'b0;
        end else begin
          m_pv = value; m_pdp = dp; m_pb = blank; m_pvld = 1'b1;
        end
      end else if (bnd && m_pvld) begin
        m_av = m_pv; m_adp = m_pdp; m_ab = m_pb; m_pvld = 1'b0;
      end
      m_c++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; value = '0; dp = '0; blank = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({seg, an, frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: seg/an/ft=%h/%h/%b expected FF/F/0", i, seg, an, frame_tick);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({seg, an, frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: seg/an/ft=%h/%h/%b expected FF/F/0", seg, an, frame_tick);
    end
  endtask

  task automatic test_basic();
    logic [31:0] lit_seg;
    logic [15:0] lit_an;
    lit_seg = 32'hF9A4B099;
    lit_an  = 16'b0111_1011_1101_1110;
    load = 1'b1; value = 16'h1234; dp = '0; blank = '0;
    step();
    load = 1'b0;
    do step(); while ((m_c % FR) != 0);
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_frame_tick: ft=%b expected 1", frame_tick);
    end
    for (int j = 0; j < FR; j++) begin
      step();
      n_checks++;
      if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_ft} ||
          seg !== lit_seg[8*(j/R) +: 8] || an !== lit_an[4*(j/R) +: 4]) begin
        n_fail++;
        $display("FAIL basic_1234[%0d]: seg/an/ft=%h/%h/%b expected %h/%h/%b", j, seg, an,
                 frame_tick, lit_seg[8*(j/R) +: 8], lit_an[4*(j/R) +: 4], exp_ft);
      end
    end
  endtask

  task automatic test_double_buffer();
    logic [31:0] lit_old, lit_new;
    lit_old = 32'hF9A4B099;
    lit_new = 32'h8883C6A1;
    for (int j = 0; j < FR; j++) begin
      if (j == 5) begin load = 1'b1; value = 16'hABCD; end
      step();
      load = 1'b0;
      n_checks++;
      if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_ft} || seg !== lit_old[8*(j/R) +: 8]) begin
        n_fail++;
        $display("FAIL dbuf_old[%0d]: seg/an/ft=%h/%h/%b expected %h/%h/%b", j, seg, an,
                 frame_tick, lit_old[8*(j/R) +: 8], exp_an, exp_ft);
      end
    end
    for (int j = 0; j < FR; j++) begin
      if (j == 3) begin load = 1'b1; value = 16'h1111; end
      if (j == 9) begin load = 1'b1; value = 16'h0F0F; end
      step();
      load = 1'b0;
      n_checks++;
      if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_ft} || seg !== lit_new[8*(j/R) +: 8]) begin
        n_fail++;
        $display("FAIL dbuf_new[%0d]: seg/an/ft=%h/%h/%b expected %h/%h/%b", j, seg, an,
                 frame_tick, lit_new[8*(j/R) +: 8], exp_an, exp_ft);
      end
    end
    for (int j = 0; j < FR; j++) begin
      step();
      n_checks++;
      if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_ft} || (j < R && seg !== 8'h8E)) begin
        n_fail++;
        $display("FAIL dbuf_last_wins[%0d]: seg/an/ft=%h/%h/%b expected %h/%h/%b", j, seg, an,
                 frame_tick, exp_seg, exp_an, exp_ft);
      end
    end
  endtask

  task automatic test_boundary_load();
    while ((m_c % FR) != FR - 1) step();
    load = 1'b1; value = 16'h5678;
    step();
    load = 1'b0;
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL bnd_frame_tick: ft=%b expected 1", frame_tick);
    end
    for (int j = 0; j < FR; j++) begin
      step();
      n_checks++;
      if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_ft} || (j < R && seg !== 8'h80)) begin
        n_fail++;
        $display("FAIL bnd_load[%0d]: seg/an/ft=%h/%h/%b expected %h/%h/%b", j, seg, an,
                 frame_tick, exp_seg, exp_an, exp_ft);
      end
    end
  endtask

  task automatic test_dp_blank();
    logic [31:0] lit;
`ifdef LEADING_ZERO_BLANK_EN
    lit = 32'hFFFF7F80;
`else
    lit = 32'hFFC04080;
`endif
    for (int j = 0; j < FR; j++) begin
      if (j == 2) begin load = 1'b1; value = 16'h0008; dp = 4'b0010; blank = 4'b1000; end
      step();
      load = 1'b0;
    end
    dp = '0; blank = '0;
    for (int j = 0; j < FR; j++) begin
      step();
      n_checks++;
      if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_ft} || seg !== lit[8*(j/R) +: 8]) begin
        n_fail++;
        $display("FAIL dp_blank[%0d]: seg/an/ft=%h/%h/%b expected %h/%h/%b", j, seg, an,
                 frame_tick, lit[8*(j/R) +: 8], exp_an, exp_ft);
      end
    end
  endtask

  task automatic test_reset_mid();
    while ((m_c % FR) != 3) step();
    load = 1'b1; value = 16'h9ABD; dp = 4'hF;
    step();
    load = 1'b0; dp = '0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({seg, an, frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: seg/an/ft=%h/%h/%b expected FF/F/0", seg, an, frame_tick);
    end
    for (int j = 0; j < 2 * FR; j++) begin
      step();
      n_checks++;
      if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_ft} || (j < R && seg !== 8'hC0)) begin
        n_fail++;
        $display("FAIL reset_discard[%0d]: seg/an/ft=%h/%h/%b expected %h/%h/%b", j, seg, an,
                 frame_tick, exp_seg, exp_an, exp_ft);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 600; j++) begin
      reset = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 5) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      dp    = 4'($urandom);
      blank = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step();
      n_checks++;
      if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_ft}) begin
        n_fail++;
        $display("FAIL random[%0d]: seg/an/ft=%h/%h/%b expected %h/%h/%b", j, seg, an,
                 frame_tick, exp_seg, exp_an, exp_ft);
      end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_double_buffer();
    test_boundary_load();
    test_dp_blank();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
